// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: segment width, blank pattern and hex decode table.
// Segment order is {A,B,C,D,E,F,G}, active-low, A in the MSB.
package seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

  // Index is the hex nibble; entry is the active-low segment pattern.
  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Datapath/display bundle for seg_scan_driver. The decimal-point signals exist
// only when SEG_DP_EN is defined.
interface seg_scan_driver_if
  import seg_pkg::*;
#(
  parameter int DIGITS = 4
);

  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic                  blank_lz;
  logic [SEG_W-1:0]      seg;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;
`ifdef SEG_DP_EN
  logic [DIGITS-1:0]     dp_in;
  logic                  dp;

  modport master (output load, value, blank_lz, dp_in,
                  input  seg, an, frame_done, dp);
  modport slave  (input  load, value, blank_lz, dp_in,
                  output seg, an, frame_done, dp);
`else
  modport master (output load, value, blank_lz,
                  input  seg, an, frame_done);
  modport slave  (input  load, value, blank_lz,
                  output seg, an, frame_done);
`endif

endinterface

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment lookup.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scan driver with leading-zero
// blanking. Optional per-digit decimal point when SEG_DP_EN is defined.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
)(
  input logic               clk,
  input logic               rst,
  seg_scan_driver_if.slave  bus
);

  localparam int PRE_W = $clog2(PRESCALE);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VAL_W = 4 * DIGITS;

  logic [PRE_W-1:0]  pre_cnt_r;
  logic [IDX_W-1:0]  idx_r;
  logic [VAL_W-1:0]  pending_r;
  logic              pend_v_r;
  logic [VAL_W-1:0]  shadow_r;
  logic              wrap_d_r;
  logic [SEG_W-1:0]  seg_r;
  logic [DIGITS-1:0] an_r;
  logic              frame_done_r;

  logic              slot_end_s;
  logic              frame_wrap_s;
  logic [3:0]        nibble_s;
  logic [SEG_W-1:0]  hex_seg_s;
  logic              upper_zero_s;
  logic              blank_s;
  logic [DIGITS-1:0] an_next_s;

  assign slot_end_s   = (pre_cnt_r == PRE_W'(PRESCALE - 1));
  assign frame_wrap_s = slot_end_s && (idx_r == IDX_W'(DIGITS - 1));
  assign nibble_s     = shadow_r[{idx_r, 2'b00} +: 4];

  // Digit idx and everything above it are zero exactly when the shifted shadow is zero.
  assign upper_zero_s = ((shadow_r >> {idx_r, 2'b00}) == {VAL_W{1'b0}});
  assign blank_s      = bus.blank_lz && (idx_r != IDX_W'(0)) && upper_zero_s;
  assign an_next_s    = ~(DIGITS'(1) << idx_r);

  hex_to_seg u_hex_to_seg (
    .nibble (nibble_s),
    .seg    (hex_seg_s)
  );

  // Prescaler and digit index; the index wrap marks the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_r <= PRE_W'(0);
      idx_r     <= IDX_W'(0);
    end else if (slot_end_s) begin
      pre_cnt_r <= PRE_W'(0);
      idx_r     <= frame_wrap_s ? IDX_W'(0) : idx_r + IDX_W'(1);
    end else begin
      pre_cnt_r <= pre_cnt_r + PRE_W'(1);
    end
  end

  // Value capture: shadow only changes on a frame wrap so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= {VAL_W{1'b0}};
      pend_v_r  <= 1'b0;
      shadow_r  <= {VAL_W{1'b0}};
    end else if (frame_wrap_s) begin
      pend_v_r <= 1'b0;
      if (bus.load) begin
        shadow_r <= bus.value;
      end else if (pend_v_r) begin
        shadow_r <= pending_r;
      end
    end else if (bus.load) begin
      pending_r <= bus.value;
      pend_v_r  <= 1'b1;
    end
  end

  // Registered display outputs, one cycle behind idx/shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r        <= SEG_OFF;
      an_r         <= {DIGITS{1'b1}};
      wrap_d_r     <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      seg_r        <= blank_s ? SEG_OFF : hex_seg_s;
      an_r         <= an_next_s;
      wrap_d_r     <= frame_wrap_s;
      frame_done_r <= wrap_d_r;
    end
  end

  assign bus.seg        = seg_r;
  assign bus.an         = an_r;
  assign bus.frame_done = frame_done_r;

`ifdef SEG_DP_EN
  logic dp_r;

  // Decimal point follows the live dp_in of the scanned digit; blanked digits stay dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_r <= 1'b1;
    end else begin
      dp_r <= blank_s ? 1'b1 : ~bus.dp_in[idx_r];
    end
  end

  assign bus.dp = dp_r;
`endif

endmodule
